// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//
// Contents:
//   state_e      - arbiter FSM encoding (IDLE=0, ISSUE=1, WAIT=2, ACK=3)
//   owner_e      - which port owns the access in flight (OWN_IF=0, OWN_D=1)
//   MEM_LAT_MAX  - largest supported memory latency
//   LAT_W        - width of the latency down-counter
//   STARVE_W     - width of the fetch starvation counter
//   lat_load()   - value loaded into the latency counter at ISSUE
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_W       = 2;
  localparam int STARVE_W    = 4;

  // The counter runs from MEM_LAT-1 down so that ACK lands exactly MEM_LAT
  // cycles after the ISSUE cycle.
  function automatic logic [LAT_W-1:0] lat_load(input int lat);
    return LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the memory port arbiter.
//
// Ports:
//   if_req_i       - fetch port is requesting
//   d_req_i        - data port is requesting
//   mask_i[1:0]    - bit 0 masks the fetch port, bit 1 masks the data port
//                    (used to drop the port currently being acked)
//   starve_cnt_i   - consecutive data grants while a fetch was waiting
//   grant_valid_o  - some unmasked port is requesting
//   grant_owner_o  - winning port (owner_e encoding), meaningful only when
//                    grant_valid_o is high
//
// Data wins by default; fetch wins when it is the only candidate or when the
// starvation counter has reached STARVE_LIMIT.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic [1:0]          mask_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                grant_valid_o,
  output logic                grant_owner_o
);

  logic if_cand;
  logic d_cand;
  logic starved;

  assign if_cand = if_req_i & ~mask_i[0];
  assign d_cand  = d_req_i  & ~mask_i[1];

  // The counter saturates at the limit, so >= is equivalent to == here but
  // stays safe if the counter were ever loaded past the limit.
  assign starved = (starve_cnt_i >= STARVE_W'(STARVE_LIMIT));

  always_comb begin
    grant_valid_o = if_cand | d_cand;
    grant_owner_o = OWN_D;
    if (if_cand && (!d_cand || starved)) begin
      grant_owner_o = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the instruction-fetch
// port and the load/store port. One access is outstanding at a time; the
// data port has priority, and a starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants with a fetch waiting.
//
// Handshake: a requester raises *_req and holds it (with stable address,
// we and wdata) until it sees the one-cycle *_ack pulse. The request is
// captured into grant registers when it wins arbitration, so later changes
// on the request inputs do not affect the access in flight. stall_* is the
// request not yet acked, used to freeze the matching pipeline stage.
//
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   if_req/if_addr                  - fetch request and address
//   if_rdata/if_ack                 - fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata       - load/store request
//   d_rdata/d_ack                   - load data and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata- memory access strobe and command
//   mem_rdata                       - memory read data, MEM_LAT after mem_en
//   stall_if, stall_mem             - per-port stall to the pipeline
//   busy                            - FSM not in IDLE
//   dbg_state, dbg_starve_cnt       - FSM state and starvation counter
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                busy,
  output logic [1:0]          dbg_state,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   gnt_addr_q, gnt_addr_d;
  logic                gnt_we_q, gnt_we_d;
  logic [DATA_W-1:0]   gnt_wdata_q, gnt_wdata_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                arb_en;
  logic [1:0]          arb_mask;
  logic                grant_valid;
  logic                grant_owner;
  logic                grant;
  logic                ack_cycle;

  // Arbitration runs in IDLE and in ACK. In ACK the port being completed
  // still has its request high for this cycle, so it is masked out; this is
  // what lets the other port take the very next access.
  assign ack_cycle = (state_q == ACK);
  assign arb_en    = (state_q == IDLE) || ack_cycle;
  assign arb_mask  = !ack_cycle        ? 2'b00 :
                     (owner_q == OWN_D) ? 2'b10 : 2'b01;

  arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb_pick (
    .if_req_i      (if_req),
    .d_req_i       (d_req),
    .mask_i        (arb_mask),
    .starve_cnt_i  (starve_cnt_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  assign grant = arb_en & grant_valid;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    gnt_addr_d   = gnt_addr_q;
    gnt_we_d     = gnt_we_q;
    gnt_wdata_d  = gnt_wdata_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      ISSUE: begin
        lat_cnt_d = lat_load(MEM_LAT);
        state_d   = (MEM_LAT == 1) ? ACK : WAIT;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q <= LAT_W'(1)) begin
          state_d = ACK;
        end
      end
      ACK: begin
        // Capture read data at the end of the ack cycle; stores leave the
        // owner's read register alone.
        if (!gnt_we_q) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = mem_rdata;
          end
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A grant in IDLE or ACK overrides the fall-back to IDLE.
    if (grant) begin
      state_d = ISSUE;
      owner_d = owner_e'(grant_owner);
      if (grant_owner == OWN_IF) begin
        gnt_addr_d  = if_addr;
        gnt_we_d    = 1'b0;
        gnt_wdata_d = '0;
      end else begin
        gnt_addr_d  = d_addr;
        gnt_we_d    = d_we;
        gnt_wdata_d = d_wdata;
      end
    end

    // Starvation counter: only meaningful while a fetch is waiting.
    if (!if_req) begin
      starve_cnt_d = '0;
    end else if (grant) begin
      if (grant_owner == OWN_IF) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q < STARVE_W'(STARVE_LIMIT)) begin
        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      gnt_addr_q   <= '0;
      gnt_we_q     <= 1'b0;
      gnt_wdata_q  <= '0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      gnt_addr_q   <= gnt_addr_d;
      gnt_we_q     <= gnt_we_d;
      gnt_wdata_q  <= gnt_wdata_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Outputs
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) & gnt_we_q;
  assign mem_addr  = gnt_addr_q;
  assign mem_wdata = gnt_wdata_q;

  assign if_ack = ack_cycle & (owner_q == OWN_IF);
  assign d_ack  = ack_cycle & (owner_q == OWN_D);

  // Read data is bypassed from the memory during the ack cycle so the
  // requester sees it together with the ack pulse.
  assign if_rdata = if_ack ? mem_rdata : if_rdata_q;
  assign d_rdata  = (d_ack && !gnt_we_q) ? mem_rdata : d_rdata_q;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;
  assign busy      = (state_q != IDLE);

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule
